i2c_reg_slave: RTL and testbench
================================

Name: i2c_reg_slave

Overview:
- I2C target (slave) with a 256 x 8 register file. It is the downstream consumer of the I2C master's bus traffic.
- Decodes START / address / register-pointer / data bytes from SDA/SCL. Writes the register file on master writes; returns register contents on master reads.
- Exposes a local write-notify and read port so system logic can observe and preset registers.
- Used as the bus partner in master/slave loopback benches and as the on-chip target model.

Parameters:
- SLAVE_ADDR, 7'h66, 7-bit I2C address this target answers to.
- RESET_VAL, 8'h00, reset value of every register-file entry.

Ports:
- sys_clock  input  1  system clock, at least 10x SCL rate; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on sys_clock rising edge.
- SCL  input  1  I2C clock; external pull-up; this block never stretches SCL.
- SDA  inout  1  I2C data, open-drain: driven 0 or released to Z, never driven 1.
- loc_addr  input  8  local read address.
- loc_rdata  output  8  register[loc_addr], registered (1-cycle latency).
- wr_strobe  output  1  one-cycle pulse per register written from the bus.
- wr_addr  output  8  register index written; valid with wr_strobe.
- wr_data  output  8  byte written; valid with wr_strobe.
- busy  output  1  high from an address-matching START until STOP, NACK, or address mismatch.

Behaviour:
- Reset (reset=0 at a clock edge):
  - Outputs: SDA released; wr_strobe=0; wr_addr=0; wr_data=0; busy=0; loc_rdata=RESET_VAL.
  - State: fsm=IDLE; register pointer=0; all registers=RESET_VAL.
  - Reset mid-transfer releases SDA the cycle after the edge. Bus activity is ignored until the next START.
- Input sync: SCL and SDA each go through 2 sync flops plus 1 history flop. Detection latency is 3 sys_clock cycles.
- Bus events:
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Data bits are sampled on SCL rising edge, MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- Global transitions:
  - START in any state goes to ADDR (repeated START supported); bit counter clears.
  - STOP in any state goes to IDLE, releases SDA and clears busy.
  - STOP/START have priority over a same-cycle SCL edge.
- ADDR: shift 8 bits.
  - Bits[7:1]==SLAVE_ADDR: go to ADDR_ACK, busy=1.
  - Otherwise: go to IDLE, SDA stays released (NACK).
- ADDR_ACK: pull SDA low on the SCL falling edge after bit 8; release it on the next SCL falling edge. Then:
  - R/W=0: go to REG.
  - R/W=1: go to RDATA, loading shift register from register[pointer].
- REG: shift 8 bits into pointer; ACK as above; go to WDATA.
- WDATA: shift 8 bits.
  - On the 8th rising edge: register[pointer] <= byte; wr_strobe pulses 1 cycle with wr_addr=pointer, wr_data=byte; pointer increments.
  - ACK as above; go to WDATA (burst).
- RDATA:
  - Drive each bit on SCL falling edge: bit=0 pulls SDA low, bit=1 releases it.
  - Bit 7 is driven on the falling edge that ends the ACK slot.
  - After 8 bits: release SDA, pointer increments, go to RDATA_ACK.
- RDATA_ACK: sample SDA on SCL rising edge.
  - 0 (ACK): reload from register[pointer], go to RDATA.
  - 1 (NACK): go to IDLE, busy=0, SDA released.
- Pointer is 8 bits and wraps 0xFF to 0x00 with no error.
- Local port: loc_rdata reflects a same-cycle bus write one cycle later (write-first).
- SCL falling edge while in IDLE: no action.

Decomposition:
- Package i2c_pkg:
  - FSM state enum.
  - Constants I2C_WRITE=0, I2C_READ=1, I2C_ADDR_W=7, I2C_BYTE_W=8.
  - Shared with the master's bench.
- Sub-module i2c_bus_sync:
  - 2-flop synchronisers and edge history.
  - Outputs scl_rise, scl_fall, sda_s, start_det, stop_det (single-cycle pulses).
  - Same reset semantics as the top.

Test Plan:
- Write addr 0x66, reg 0x55, data 0x44, STOP:
  - ACK in all three 9th-clock slots.
  - wr_strobe once, with wr_addr=0x55, wr_data=0x44.
  - loc_addr=0x55 gives loc_rdata=0x44.
  - busy returns 0 after STOP.
- Address 0x67 write: SDA high in 9th slot (NACK), no wr_strobe, busy stays 0, register file unchanged.
- Burst write: reg 0x10, data 0xA1,0xA2,0xA3 → regs 0x10..0x12 = A1,A2,A3; three wr_strobe pulses.
- Write 0xFE,0xFF,0x00 starting at reg 0xFF → reg 0xFF=0xFE, 0x00=0xFF, 0x01=0x00 (pointer wrap).
- Read sequence:
  - Preload reg 0x55=0x44, 0x56=0x99.
  - Send write addr, reg 0x55, repeated START, addr 0x66 read.
  - Expect byte 0x44; master ACKs; expect 0x99; master NACK then STOP → IDLE, SDA released.
- reset=0 asserted while target drives an ACK low:
  - SDA is Z one cycle after the edge; busy=0; all registers are 0x00.
  - A subsequent full write transaction completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
//   Shared I2C definitions used by the register-file target and by the master
//   side benches:
//     - i2c_state_t : protocol FSM states of the target
//     - I2C_WRITE / I2C_READ : value of the R/W bit in the address byte
//     - I2C_ADDR_W / I2C_BYTE_W : widths of the 7-bit address and a data byte
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam logic I2C_WRITE  = 1'b0;
  localparam logic I2C_READ   = 1'b1;
  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK
  } i2c_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
//   Brings the asynchronous SCL/SDA lines into the sys_clock domain and turns
//   them into single-cycle bus events.
//   Ports:
//     sys_clock  : system clock, all logic on its rising edge
//     reset      : synchronous active-low reset
//     i_scl      : raw I2C clock line
//     i_sda      : raw I2C data line
//     scl_rise   : one-cycle pulse, synchronised SCL went 0 -> 1
//     scl_fall   : one-cycle pulse, synchronised SCL went 1 -> 0
//     sda_s      : synchronised SDA level
//     start_det  : one-cycle pulse, SDA fell while SCL high
//     stop_det   : one-cycle pulse, SDA rose while SCL high
// ---------------------------------------------------------------------------
module i2c_bus_sync (
  input  logic sys_clock,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic r_sclMeta;
  logic r_sclSync;
  logic r_sclHist;
  logic r_sdaMeta;
  logic r_sdaSync;
  logic r_sdaHist;

  // Two synchroniser flops plus one history flop per line. Everything resets
  // to the released (high) bus level so leaving reset never looks like an edge.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
      r_sclHist <= 1'b1;
      r_sdaMeta <= 1'b1;
      r_sdaSync <= 1'b1;
      r_sdaHist <= 1'b1;
    end else begin
      r_sclMeta <= i_scl;
      r_sclSync <= r_sclMeta;
      r_sclHist <= r_sclSync;
      r_sdaMeta <= i_sda;
      r_sdaSync <= r_sdaMeta;
      r_sdaHist <= r_sdaSync;
    end
  end

  // START/STOP require SCL high in both the current and previous sample so an
  // SDA change racing an SCL edge is not mistaken for a bus condition.
  assign scl_rise  =  r_sclSync & ~r_sclHist;
  assign scl_fall  = ~r_sclSync &  r_sclHist;
  assign sda_s     =  r_sdaSync;
  assign start_det =  r_sclSync &  r_sclHist &  r_sdaHist & ~r_sdaSync;
  assign stop_det  =  r_sclSync &  r_sclHist & ~r_sdaHist &  r_sdaSync;

endmodule

// File: rtl/i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// i2c_reg_slave
//   I2C target with a 256 x 8 register file. A master write sets the register
//   pointer with its first data byte and stores every following byte at the
//   auto-incrementing pointer. A master read returns bytes starting at the
//   current pointer, again auto-incrementing. SCL is never stretched.
//   Ports:
//     sys_clock  : system clock (>= 10x SCL), all logic on its rising edge
//     reset      : synchronous active-low reset
//     SCL        : I2C clock input
//     SDA        : I2C data, open drain (driven 0 or released)
//     loc_addr   : local read address
//     loc_rdata  : register[loc_addr], one cycle latency, write-first
//     wr_strobe  : one-cycle pulse per register written from the bus
//     wr_addr    : index of the register written, valid with wr_strobe
//     wr_data    : byte written, valid with wr_strobe
//     busy       : high from an address-matching START until STOP/NACK/mismatch
// ---------------------------------------------------------------------------
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h66,
  parameter logic [I2C_BYTE_W-1:0] RESET_VAL  = 8'h00
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  input  logic [7:0]            loc_addr,
  output logic [I2C_BYTE_W-1:0] loc_rdata,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic                  busy
);

  logic w_sclRise;
  logic w_sclFall;
  logic w_sdaS;
  logic w_startDet;
  logic w_stopDet;

  i2c_state_t r_state;
  i2c_state_t w_nextState;

  logic [I2C_BYTE_W-1:0] r_shift;
  logic [I2C_BYTE_W-1:0] w_nxtShift;
  logic [3:0]            r_bitCnt;
  logic [3:0]            w_nxtBitCnt;
  logic [3:0]            w_bitCntInc;
  logic [7:0]            r_ptr;
  logic [7:0]            w_nxtPtr;
  logic                  r_sdaLow;
  logic                  w_nxtSdaLow;
  logic                  r_busy;
  logic                  w_nxtBusy;
  logic                  r_ackPhase;
  logic                  w_nxtAckPhase;
  logic                  r_rw;
  logic                  w_nxtRw;
  logic                  w_wrEn;
  logic [I2C_BYTE_W-1:0] w_shiftIn;
  logic [I2C_BYTE_W-1:0] w_memRd;

  logic [I2C_BYTE_W-1:0] r_mem [256];
  logic                  r_wrStrobe;
  logic [7:0]            r_wrAddr;
  logic [I2C_BYTE_W-1:0] r_wrData;
  logic [I2C_BYTE_W-1:0] r_locRdata;

  i2c_bus_sync u_sync (
    .sys_clock (sys_clock),
    .reset     (reset),
    .i_scl     (SCL),
    .i_sda     (SDA),
    .scl_rise  (w_sclRise),
    .scl_fall  (w_sclFall),
    .sda_s     (w_sdaS),
    .start_det (w_startDet),
    .stop_det  (w_stopDet)
  );

  // Open drain: only ever pull low, otherwise float to the external pull-up.
  assign SDA = r_sdaLow ? 1'b0 : 1'bz;

  assign w_shiftIn   = {r_shift[I2C_BYTE_W-2:0], w_sdaS};
  assign w_bitCntInc = r_bitCnt + 4'd1;
  assign w_memRd     = r_mem[r_ptr];

  // FSM and bus datapath state register.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      r_ptr      <= '0;
      r_sdaLow   <= 1'b0;
      r_busy     <= 1'b0;
      r_ackPhase <= 1'b0;
      r_rw       <= I2C_WRITE;
    end else begin
      r_state    <= w_nextState;
      r_shift    <= w_nxtShift;
      r_bitCnt   <= w_nxtBitCnt;
      r_ptr      <= w_nxtPtr;
      r_sdaLow   <= w_nxtSdaLow;
      r_busy     <= w_nxtBusy;
      r_ackPhase <= w_nxtAckPhase;
      r_rw       <= w_nxtRw;
    end
  end

  // Next-state logic. STOP and START are checked before any SCL edge so a bus
  // condition always wins. ACK slots use r_ackPhase: the first SCL fall after
  // a byte pulls SDA low, the second fall ends the slot. For reads, the fall
  // ending the address ACK also drives the first data bit (MSB).
  always_comb begin
    w_nextState   = r_state;
    w_nxtShift    = r_shift;
    w_nxtBitCnt   = r_bitCnt;
    w_nxtPtr      = r_ptr;
    w_nxtSdaLow   = r_sdaLow;
    w_nxtBusy     = r_busy;
    w_nxtAckPhase = r_ackPhase;
    w_nxtRw       = r_rw;
    w_wrEn        = 1'b0;

    if (w_stopDet) begin
      w_nextState   = IDLE;
      w_nxtSdaLow   = 1'b0;
      w_nxtBusy     = 1'b0;
      w_nxtBitCnt   = '0;
      w_nxtAckPhase = 1'b0;
    end else if (w_startDet) begin
      w_nextState   = ADDR;
      w_nxtSdaLow   = 1'b0;
      w_nxtBitCnt   = '0;
      w_nxtAckPhase = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_sclRise) begin
            w_nxtShift = w_shiftIn;
            if (r_bitCnt == 4'd7) begin
              w_nxtBitCnt = '0;
              if (w_shiftIn[7:1] == SLAVE_ADDR) begin
                w_nextState = ADDR_ACK;
                w_nxtBusy   = 1'b1;
                w_nxtRw     = w_shiftIn[0];
              end else begin
                w_nextState = IDLE;
                w_nxtBusy   = 1'b0;
              end
            end else begin
              w_nxtBitCnt = w_bitCntInc;
            end
          end
        end

        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (w_sclFall) begin
            if (!r_ackPhase) begin
              w_nxtSdaLow   = 1'b1;
              w_nxtAckPhase = 1'b1;
            end else begin
              w_nxtAckPhase = 1'b0;
              w_nxtSdaLow   = 1'b0;
              w_nxtBitCnt   = '0;
              if (r_state == ADDR_ACK) begin
                if (r_rw == I2C_READ) begin
                  w_nextState = RDATA;
                  w_nxtSdaLow = ~w_memRd[7];
                  w_nxtShift  = {w_memRd[6:0], 1'b0};
                  w_nxtBitCnt = 4'd1;
                end else begin
                  w_nextState = REG;
                end
              end else begin
                w_nextState = WDATA;
              end
            end
          end
        end

        REG: begin
          if (w_sclRise) begin
            w_nxtShift = w_shiftIn;
            if (r_bitCnt == 4'd7) begin
              w_nxtPtr    = w_shiftIn;
              w_nxtBitCnt = '0;
              w_nextState = REG_ACK;
            end else begin
              w_nxtBitCnt = w_bitCntInc;
            end
          end
        end

        WDATA: begin
          if (w_sclRise) begin
            w_nxtShift = w_shiftIn;
            if (r_bitCnt == 4'd7) begin
              w_wrEn      = 1'b1;
              w_nxtPtr    = r_ptr + 8'd1;
              w_nxtBitCnt = '0;
              w_nextState = WDATA_ACK;
            end else begin
              w_nxtBitCnt = w_bitCntInc;
            end
          end
        end

        // r_bitCnt counts bits already put on the bus; the fall after the
        // eighth bit hands SDA back to the master for its ACK/NACK.
        RDATA: begin
          if (w_sclFall) begin
            if (r_bitCnt == 4'd8) begin
              w_nxtSdaLow = 1'b0;
              w_nxtPtr    = r_ptr + 8'd1;
              w_nxtBitCnt = '0;
              w_nextState = RDATA_ACK;
            end else begin
              w_nxtSdaLow = ~r_shift[7];
              w_nxtShift  = {r_shift[6:0], 1'b0};
              w_nxtBitCnt = w_bitCntInc;
            end
          end
        end

        RDATA_ACK: begin
          if (w_sclRise) begin
            if (!w_sdaS) begin
              w_nextState = RDATA;
              w_nxtShift  = w_memRd;
              w_nxtBitCnt = '0;
            end else begin
              w_nextState = IDLE;
              w_nxtBusy   = 1'b0;
              w_nxtSdaLow = 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // Register file, cleared to RESET_VAL on reset.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        r_mem[i] <= RESET_VAL;
      end
    end else if (w_wrEn) begin
      r_mem[r_ptr] <= w_shiftIn;
    end
  end

  // Write-notify outputs hold their last value between strobes.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_wrStrobe <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_wrStrobe <= w_wrEn;
      if (w_wrEn) begin
        r_wrAddr <= r_ptr;
        r_wrData <= w_shiftIn;
      end
    end
  end

  // Local read port forwards a same-cycle bus write so the new byte is seen
  // one cycle later rather than two.
  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      r_locRdata <= RESET_VAL;
    end else if (w_wrEn && (r_ptr == loc_addr)) begin
      r_locRdata <= w_shiftIn;
    end else begin
      r_locRdata <= r_mem[loc_addr];
    end
  end

  assign loc_rdata = r_locRdata;
  assign wr_strobe = r_wrStrobe;
  assign wr_addr   = r_wrAddr;
  assign wr_data   = r_wrData;
  assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_slave
//   Directed bench: a bit-banged I2C master drives SCL/SDA (SDA open drain
//   with a pull-up) and checks ACKs, read data, write notifications, busy and
//   the local read port against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_reg_slave;

  localparam int Q = 6;

  logic       sysClock;
  logic       resetN;
  logic       sclDrv;
  logic       mSdaLow;
  wire        sda;
  logic [7:0] locAddr;
  logic [7:0] locRdata;
  logic       wrStrobe;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       busyO;

  int         checks;
  int         errors;
  int         strobeCount;
  logic [7:0] lastWrAddr;
  logic [7:0] lastWrData;

  logic       ack;
  logic       bitS;
  logic [7:0] rdByte;

  assign sda = mSdaLow ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_slave #(
    .SLAVE_ADDR (7'h66),
    .RESET_VAL  (8'h00)
  ) dut (
    .sys_clock (sysClock),
    .reset     (resetN),
    .SCL       (sclDrv),
    .SDA       (sda),
    .loc_addr  (locAddr),
    .loc_rdata (locRdata),
    .wr_strobe (wrStrobe),
    .wr_addr   (wrAddr),
    .wr_data   (wrData),
    .busy      (busyO)
  );

  // 100 MHz system clock.
  initial begin
    sysClock = 1'b0;
    forever #5 sysClock = ~sysClock;
  end

  // Log every write notification, sampled away from the active edge.
  initial begin
    strobeCount = 0;
    lastWrAddr  = '0;
    lastWrData  = '0;
  end

  always @(negedge sysClock) begin
    if (wrStrobe === 1'b1) begin
      strobeCount++;
      lastWrAddr = wrAddr;
      lastWrData = wrData;
    end
  end

  // Hard bound on the whole run.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge sysClock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Point the local read port at an address and let the registered data settle.
  task automatic applyStimulus(input logic [7:0] addr);
    locAddr = addr;
    waitCycles(2);
  endtask

  task automatic i2cStart();
    mSdaLow = 1'b0;
    waitCycles(Q);
    sclDrv = 1'b1;
    waitCycles(Q);
    mSdaLow = 1'b1;
    waitCycles(Q);
    sclDrv = 1'b0;
    waitCycles(Q);
  endtask

  task automatic i2cStop();
    mSdaLow = 1'b1;
    waitCycles(Q);
    sclDrv = 1'b1;
    waitCycles(Q);
    mSdaLow = 1'b0;
    waitCycles(Q);
  endtask

  // One SCL period: set SDA a quarter into the low phase, sample mid-high.
  task automatic clockBit(input logic b, output logic s);
    mSdaLow = ~b;
    waitCycles(Q);
    sclDrv = 1'b1;
    waitCycles(Q);
    s = sda;
    waitCycles(Q);
    sclDrv = 1'b0;
    waitCycles(Q);
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(b[i], s);
    end
    clockBit(1'b1, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clockBit(1'b1, s);
      d = {d[6:0], s};
    end
    clockBit(~masterAck, s);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    resetN  = 1'b0;
    sclDrv  = 1'b1;
    mSdaLow = 1'b0;
    locAddr = 8'h00;
    waitCycles(4);
    resetN = 1'b1;
    waitCycles(2);

    // Reset state
    checkOutput("rst_sda", 32'(sda), 32'h1);
    checkOutput("rst_busy", 32'(busyO), 32'h0);
    checkOutput("rst_wr_strobe", 32'(wrStrobe), 32'h0);
    checkOutput("rst_wr_addr", 32'(wrAddr), 32'h0);
    checkOutput("rst_wr_data", 32'(wrData), 32'h0);
    checkOutput("rst_loc_rdata", 32'(locRdata), 32'h0);

    // Single write: addr 0x66 W, reg 0x55, data 0x44
    i2cStart();
    writeByte(8'hCC, ack);
    checkOutput("w1_ack_addr", 32'(ack), 32'h1);
    checkOutput("w1_busy", 32'(busyO), 32'h1);
    writeByte(8'h55, ack);
    checkOutput("w1_ack_reg", 32'(ack), 32'h1);
    writeByte(8'h44, ack);
    checkOutput("w1_ack_data", 32'(ack), 32'h1);
    i2cStop();
    waitCycles(6);
    checkOutput("w1_strobes", 32'(strobeCount), 32'd1);
    checkOutput("w1_wr_addr", 32'(lastWrAddr), 32'h55);
    checkOutput("w1_wr_data", 32'(lastWrData), 32'h44);
    checkOutput("w1_busy_after_stop", 32'(busyO), 32'h0);
    applyStimulus(8'h55);
    checkOutput("w1_loc_55", 32'(locRdata), 32'h44);

    // Wrong address 0x67: NACK, nothing written
    i2cStart();
    writeByte(8'hCE, ack);
    checkOutput("nack_ack", 32'(ack), 32'h0);
    checkOutput("nack_busy", 32'(busyO), 32'h0);
    writeByte(8'h55, ack);
    writeByte(8'h11, ack);
    i2cStop();
    waitCycles(6);
    checkOutput("nack_strobes", 32'(strobeCount), 32'd1);
    applyStimulus(8'h55);
    checkOutput("nack_loc_55", 32'(locRdata), 32'h44);

    // Burst write at 0x10
    i2cStart();
    writeByte(8'hCC, ack);
    writeByte(8'h10, ack);
    writeByte(8'hA1, ack);
    writeByte(8'hA2, ack);
    writeByte(8'hA3, ack);
    checkOutput("burst_ack_last", 32'(ack), 32'h1);
    i2cStop();
    waitCycles(6);
    checkOutput("burst_strobes", 32'(strobeCount), 32'd4);
    checkOutput("burst_last_addr", 32'(lastWrAddr), 32'h12);
    checkOutput("burst_last_data", 32'(lastWrData), 32'hA3);
    applyStimulus(8'h10);
    checkOutput("burst_loc_10", 32'(locRdata), 32'hA1);
    applyStimulus(8'h11);
    checkOutput("burst_loc_11", 32'(locRdata), 32'hA2);
    applyStimulus(8'h12);
    checkOutput("burst_loc_12", 32'(locRdata), 32'hA3);

    // Pointer wrap from 0xFF
    i2cStart();
    writeByte(8'hCC, ack);
    writeByte(8'hFF, ack);
    writeByte(8'hFE, ack);
    writeByte(8'hFF, ack);
    writeByte(8'h00, ack);
    i2cStop();
    waitCycles(6);
    checkOutput("wrap_strobes", 32'(strobeCount), 32'd7);
    checkOutput("wrap_last_addr", 32'(lastWrAddr), 32'h01);
    applyStimulus(8'hFF);
    checkOutput("wrap_loc_ff", 32'(locRdata), 32'hFE);
    applyStimulus(8'h00);
    checkOutput("wrap_loc_00", 32'(locRdata), 32'hFF);
    applyStimulus(8'h01);
    checkOutput("wrap_loc_01", 32'(locRdata), 32'h00);

    // Preload 0x56 = 0x99 (0x55 already holds 0x44)
    i2cStart();
    writeByte(8'hCC, ack);
    writeByte(8'h56, ack);
    writeByte(8'h99, ack);
    i2cStop();
    waitCycles(6);

    // Read: set pointer 0x55, repeated START, read two bytes
    i2cStart();
    writeByte(8'hCC, ack);
    writeByte(8'h55, ack);
    i2cStart();
    writeByte(8'hCD, ack);
    checkOutput("rd_ack_addr", 32'(ack), 32'h1);
    readByte(1'b1, rdByte);
    checkOutput("rd_byte0", 32'(rdByte), 32'h44);
    checkOutput("rd_busy", 32'(busyO), 32'h1);
    readByte(1'b0, rdByte);
    checkOutput("rd_byte1", 32'(rdByte), 32'h99);
    checkOutput("rd_busy_after_nack", 32'(busyO), 32'h0);
    i2cStop();
    waitCycles(6);
    checkOutput("rd_sda_released", 32'(sda), 32'h1);
    checkOutput("rd_strobes", 32'(strobeCount), 32'd8);

    // Reset while the target holds the address ACK low
    i2cStart();
    for (int i = 7; i >= 0; i--) begin
      clockBit(((8'hCC >> i) & 8'h01) != 8'h00, bitS);
    end
    mSdaLow = 1'b0;
    waitCycles(Q);
    sclDrv = 1'b1;
    waitCycles(Q);
    checkOutput("rst_mid_ack_driven", 32'(sda), 32'h0);
    resetN = 1'b0;
    waitCycles(1);
    checkOutput("rst_mid_sda", 32'(sda), 32'h1);
    checkOutput("rst_mid_busy", 32'(busyO), 32'h0);
    waitCycles(3);
    resetN = 1'b1;
    waitCycles(2);
    applyStimulus(8'h55);
    checkOutput("rst_mid_loc_55", 32'(locRdata), 32'h00);
    applyStimulus(8'h10);
    checkOutput("rst_mid_loc_10", 32'(locRdata), 32'h00);
    applyStimulus(8'hFF);
    checkOutput("rst_mid_loc_ff", 32'(locRdata), 32'h00);
    sclDrv = 1'b0;
    waitCycles(Q);

    // Full write after the mid-transfer reset
    i2cStart();
    writeByte(8'hCC, ack);
    checkOutput("post_ack_addr", 32'(ack), 32'h1);
    writeByte(8'h20, ack);
    writeByte(8'h5A, ack);
    checkOutput("post_ack_data", 32'(ack), 32'h1);
    i2cStop();
    waitCycles(6);
    checkOutput("post_strobes", 32'(strobeCount), 32'd9);
    checkOutput("post_wr_addr", 32'(lastWrAddr), 32'h20);
    checkOutput("post_wr_data", 32'(lastWrData), 32'h5A);
    checkOutput("post_busy", 32'(busyO), 32'h0);
    applyStimulus(8'h20);
    checkOutput("post_loc_20", 32'(locRdata), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
